// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: sequences an external simple dual-port RAM (registered
// read, one-cycle latency) as a synchronous FIFO. The push side cannot stall,
// so words offered while full are dropped and recorded in a sticky overrun
// flag. The pop side is valid/ready, with one extra word of storage in the
// RAM's own read register.
module dpram_fifo_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int THRESH = 128
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   level,
    output logic              overrun,
    output logic              above
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   ram_count;
    logic              full;
    logic              push;
    logic              rd;

    // Full means every RAM location holds an unread word; the output
    // register is counted separately in level.
    assign full     = (ram_count == (ADDR_W+1)'(DEPTH));
    assign in_ready = !full;

    // A flush cycle discards whatever push or read would have happened, so
    // neither RAM port is enabled while it is asserted.
    assign push = in_valid && !full && !flush;
    assign rd   = (ram_count != '0) && (!out_valid || out_ready) && !flush;

    assign mem_we    = push;
    assign mem_waddr = wptr;
    assign mem_wdata = in_data;
    assign mem_re    = rd;
    assign mem_raddr = rptr;

    // The RAM read register is the output register: it holds its value while
    // mem_re is low, which keeps out_data stable during a stall.
    assign out_data = mem_rdata;

    assign level = ram_count + (ADDR_W+1)'(out_valid);
    assign above = (32'(level) >= THRESH);

    // Pointer, occupancy, output-valid and overrun bookkeeping; reset and
    // flush both return everything to the empty state.
    always_ff @(posedge ck) begin
        if (rst || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_count <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd) begin
                rptr <= rptr + ADDR_W'(1);
            end
            case ({push, rd})
                2'b10:   ram_count <= ram_count + (ADDR_W+1)'(1);
                2'b01:   ram_count <= ram_count - (ADDR_W+1)'(1);
                default: ram_count <= ram_count;
            endcase
            out_valid <= rd || (out_valid && !out_ready);
            if (in_valid && full) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: self-checking bench for dpram_fifo_ctrl with a
// behavioural registered-read RAM, a data scoreboard and a level model.
module tb_dpram_fifo_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int THRESH = 128;

    logic              ck = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   level;
    logic              overrun;
    logic              above;

    int n_compared = 0;
    int n_failed   = 0;

    logic [DATA_W-1:0] sb[$];
    int                lvl_model  = 0;
    int                drop_count = 0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    typedef struct {
        logic              rst;
        logic              flush;
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              orr;
        logic [ADDR_W:0]   lvl;
        logic              vld;
        logic              rdy;
        logic              ovr;
        logic              chk;
        logic [DATA_W-1:0] data;
    } vec_t;

    vec_t vecs[$];

    dpram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .THRESH(THRESH)) dut (
        .ck(ck), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .level(level), .overrun(overrun), .above(above)
    );

    // Free-running clock
    always #5 ck = ~ck;

    // Simple dual-port RAM with registered read that holds when re is low
    always @(posedge ck) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [DATA_W-1:0] d, input logic orr);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic f, input logic iv,
                           input logic [DATA_W-1:0] d, input logic orr,
                           input logic [ADDR_W:0] lvl, input logic vld,
                           input logic rdy, input logic ovr, input logic chk,
                           input logic [DATA_W-1:0] data);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.orr = orr;
        v.lvl = lvl; v.vld = vld; v.rdy = rdy; v.ovr = ovr;
        v.chk = chk; v.data = data;
        vecs.push_back(v);
    endtask

    task automatic wait_valid(input int limit, input string name);
        int k = 0;
        while (!out_valid && k < limit) begin
            tick();
            k++;
        end
        checkOutput(name, 32'(out_valid), 32'd1);
    endtask

    // Mid-cycle monitor: scoreboard, level model, stall stability and
    // read/write address hazard checks
    always @(negedge ck) begin
        if (rst || flush) begin
            if (flush && !rst) begin
                checkOutput("flush_we", 32'(mem_we), 32'd0);
                checkOutput("flush_re", 32'(mem_re), 32'd0);
            end
            sb.delete();
            lvl_model  = 0;
            stall_prev = 1'b0;
        end else begin
            checkOutput("level_model", 32'(level), 32'(lvl_model));
            checkOutput("above_model", 32'(above), 32'(lvl_model >= THRESH));
            if (mem_we && mem_re)
                checkOutput("rw_addr_differ", 32'(mem_waddr != mem_raddr), 32'd1);
            if (stall_prev) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_compared++;
                    n_failed++;
                    $display("[TB] FAIL pop_unexpected: got 0x%0h, want no word", out_data);
                end else begin
                    checkOutput("sb_data", 32'(out_data), 32'(sb.pop_front()));
                end
                lvl_model--;
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                lvl_model++;
            end else if (in_valid) begin
                drop_count++;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    initial begin
        logic [3:0] pat;
        int         base;
        int         k;

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Basic push then drain, one row per clock
        add_vec(1, 0, 0, 16'h0000, 0, 9'd0, 0, 1, 0, 0, 16'h0000);
        add_vec(0, 0, 1, 16'h0001, 0, 9'd1, 0, 1, 0, 0, 16'h0000);
        add_vec(0, 0, 1, 16'h0002, 0, 9'd2, 1, 1, 0, 1, 16'h0001);
        add_vec(0, 0, 1, 16'h0003, 0, 9'd3, 1, 1, 0, 1, 16'h0001);
        add_vec(0, 0, 1, 16'h0004, 0, 9'd4, 1, 1, 0, 1, 16'h0001);
        add_vec(0, 0, 1, 16'h0005, 0, 9'd5, 1, 1, 0, 1, 16'h0001);
        add_vec(0, 0, 0, 16'h0000, 0, 9'd5, 1, 1, 0, 1, 16'h0001);
        add_vec(0, 0, 0, 16'h0000, 1, 9'd4, 1, 1, 0, 1, 16'h0002);
        add_vec(0, 0, 0, 16'h0000, 1, 9'd3, 1, 1, 0, 1, 16'h0003);
        add_vec(0, 0, 0, 16'h0000, 1, 9'd2, 1, 1, 0, 1, 16'h0004);
        add_vec(0, 0, 0, 16'h0000, 1, 9'd1, 1, 1, 0, 1, 16'h0005);
        add_vec(0, 0, 0, 16'h0000, 1, 9'd0, 0, 1, 0, 0, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].orr);
            tick();
            checkOutput($sformatf("t1_level[%0d]", i), 32'(level), 32'(vecs[i].lvl));
            checkOutput($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].vld));
            checkOutput($sformatf("t1_ready[%0d]", i), 32'(in_ready), 32'(vecs[i].rdy));
            checkOutput($sformatf("t1_overrun[%0d]", i), 32'(overrun), 32'(vecs[i].ovr));
            checkOutput($sformatf("t1_above[%0d]", i), 32'(above), 32'd0);
            if (vecs[i].chk)
                checkOutput($sformatf("t1_data[%0d]", i), 32'(out_data), 32'(vecs[i].data));
        end

        // Fill to capacity and overflow by one word
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        drop_count = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h1000 + i), 1'b0);
            tick();
        end
        checkOutput("t2_level256", 32'(level), 32'd256);
        checkOutput("t2_ready256", 32'(in_ready), 32'd1);
        checkOutput("t2_valid256", 32'(out_valid), 32'd1);
        checkOutput("t2_data256", 32'(out_data), 32'h1000);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1100, 1'b0);
        tick();
        checkOutput("t2_level257", 32'(level), 32'd257);
        checkOutput("t2_ready257", 32'(in_ready), 32'd0);
        checkOutput("t2_overrun_pre", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1101, 1'b0);
        tick();
        checkOutput("t2_level_drop", 32'(level), 32'd257);
        checkOutput("t2_overrun", 32'(overrun), 32'd1);
        checkOutput("t2_drops", 32'(drop_count), 32'd1);

        // Full FIFO with push and pop both active: only the first push drops
        base = drop_count;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h1102 + i), 1'b1);
            tick();
        end
        checkOutput("t3_drops", 32'(drop_count - base), 32'd1);
        checkOutput("t3_level", 32'(level), 32'd256);
        checkOutput("t3_overrun", 32'(overrun), 32'd1);

        // Flush mid-stream with a push in the same cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b1);
        tick();
        checkOutput("t5_level", 32'(level), 32'd0);
        checkOutput("t5_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_overrun", 32'(overrun), 32'd0);
        checkOutput("t5_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        wait_valid(8, "t5_wait_valid");
        checkOutput("t5_first_data", 32'(out_data), 32'h1234);
        tick();

        // Stream with out_ready toggling 1,0,0,1, then drain
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        pat = 4'b1001;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h0100 + i), pat[i % 4]);
            tick();
        end
        checkOutput("t4_above_high", 32'(above), 32'd1);
        k = 0;
        while (level != 0 && k < 2000) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, pat[k % 4]);
            tick();
            k++;
        end
        checkOutput("t4_drained", 32'(level), 32'd0);
        checkOutput("t4_above_low", 32'(above), 32'd0);
        checkOutput("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset from level 40 with overrun set
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h2000 + i), 1'b0);
            tick();
        end
        for (int i = 0; i < 217; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
            tick();
        end
        checkOutput("t6_level40", 32'(level), 32'd40);
        checkOutput("t6_overrun_set", 32'(overrun), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
        tick();
        checkOutput("t6_level", 32'(level), 32'd0);
        checkOutput("t6_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_overrun", 32'(overrun), 32'd0);
        checkOutput("t6_above", 32'(above), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        wait_valid(8, "t6_wait_valid");
        checkOutput("t6_first_data", 32'(out_data), 32'hBEEF);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
